traffic_ctrl: RTL

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

---
 rtl/traffic_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl.sv
// Pedestrian-crossing traffic light controller (Moore FSM with phase timer).
// Define PED_FLASH_EN to add the flashing-walk CLEAR phase.
module traffic_ctrl #(
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 20,
    parameter int T_AMBER     = 4,
    parameter int T_WALK      = 30,
    parameter int T_CLEAR     = 12,
    parameter int FLASH_HALF  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       T,
    output logic       CAR_V,
    output logic       CAR_A,
    output logic       CAR_R,
    output logic       PED_W,
    output logic       PED_B,
    output logic       REQ_PEND,
    output logic [2:0] PHASE
);

    typedef enum logic [2:0] {
        S_GREEN  = 3'd0,
        S_AMBER1 = 3'd1,
        S_WALK   = 3'd2,
        S_CLEAR  = 3'd3,
        S_AMBER2 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] GMAX = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] AMAX = CNT_W'(T_AMBER - 1);
    localparam logic [CNT_W-1:0] WMAX = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;

`ifdef PED_FLASH_EN
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] FMAX = CNT_W'(FLASH_HALF - 1);

    logic             flash_q, flash_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flash_q <= 1'b1;
            fcnt_q  <= '0;
        end else begin
            flash_q <= flash_d;
            fcnt_q  <= fcnt_d;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_GREEN;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q | T;
`ifdef PED_FLASH_EN
        flash_d = flash_q;
        fcnt_d  = fcnt_q;
`endif
        case (state_q)
            S_GREEN: begin
                // Counter parks at its limit until a request arrives
                if (EN) begin
                    if (cnt_q != GMAX) begin
                        cnt_d = cnt_q + ONE;
                    end else if (req_q) begin
                        state_d = S_AMBER1;
                        cnt_d   = '0;
                    end
                end
            end
            S_AMBER1: begin
                if (EN) begin
                    if (cnt_q == AMAX) begin
                        state_d = S_WALK;
                        cnt_d   = '0;
                        req_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            S_WALK: begin
                if (EN) begin
                    if (cnt_q == WMAX) begin
                        cnt_d = '0;
`ifdef PED_FLASH_EN
                        state_d = S_CLEAR;
                        flash_d = 1'b1;
                        fcnt_d  = '0;
`else
                        state_d = S_AMBER2;
`endif
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
`ifdef PED_FLASH_EN
            S_CLEAR: begin
                if (EN) begin
                    if (cnt_q == CMAX) begin
                        state_d = S_AMBER2;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                    if (fcnt_q == FMAX) begin
                        fcnt_d  = '0;
                        flash_d = ~flash_q;
                    end else begin
                        fcnt_d = fcnt_q + ONE;
                    end
                end
            end
`endif
            S_AMBER2: begin
                if (EN) begin
                    if (cnt_q == AMAX) begin
                        state_d = S_GREEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: begin
                // Recover from any unreachable code regardless of EN
                state_d = S_GREEN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        CAR_V = 1'b0;
        CAR_A = 1'b0;
        CAR_R = 1'b0;
        PED_W = 1'b0;
        PED_B = 1'b0;
        case (state_q)
            S_GREEN: begin
                CAR_V = 1'b1;
                PED_B = 1'b1;
            end
            S_AMBER1, S_AMBER2: begin
                CAR_A = 1'b1;
                PED_B = 1'b1;
            end
            S_WALK: begin
                CAR_R = 1'b1;
                PED_W = 1'b1;
            end
`ifdef PED_FLASH_EN
            S_CLEAR: begin
                CAR_R = 1'b1;
                PED_W = flash_q;
            end
`endif
            default: begin
                CAR_R = 1'b1;
                PED_B = 1'b1;
            end
        endcase
    end

    assign REQ_PEND = req_q;
    assign PHASE    = state_q;

endmodule
